rr_mux_arbiter: RTL

//  Round-robin arbiter sharing one 8:1, 4-bit data mux among 8 requesters.

---
 rtl/rr_mux_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 25 ++
 rtl/rr_mux_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rr_mux_arb_pkg.sv
// Shared constants, FSM state type and select type for the round-robin mux arbiter.
// Included by rr_pick and rr_mux_arbiter.
package rr_mux_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int DW    = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOCKED
    } arb_state_t;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [N_REQ-1:0] req_vec_t;

    function automatic req_vec_t idx_to_onehot(input sel_t idx);
        return req_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: finds the first asserted request at or after ptr,
// wrapping 7->0. Purely combinational.
module rr_pick
    import rr_mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Walk from the lowest priority upward so the highest-priority hit wins last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[ptr + sel_t'(i)]) begin
                idx   = ptr + sel_t'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared 8:1 data mux with registered grant, select and data.
// Optional burst locking is compiled in with `define ARB_LOCK_EN.
module rr_mux_arbiter
    import rr_mux_arb_pkg::*;
#(
    parameter int DW        = 4,
    parameter int MAX_BURST = 4
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
`ifdef ARB_LOCK_EN
    input  logic [N_REQ-1:0]    lock,
`endif
    input  logic [N_REQ*DW-1:0] din,
    output logic [N_REQ-1:0]    gnt,
    output logic [SEL_W-1:0]    sel,
    output logic [DW-1:0]       dout,
    output logic                dout_valid,
    output logic                busy
);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    sel_t             sel_q, sel_d;
    sel_t             ptr_q, ptr_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic             valid_q, valid_d;

    logic [DW-1:0]    word [N_REQ];
    sel_t             pick_idx;
    logic             pick_found;
    logic             hold;

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            word[k] = din[k*DW +: DW];
        end
    end

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    // burst_cnt counts cycles the current owner has held gnt, the grant cycle included.
    assign hold = (state_q == GRANT || state_q == LOCKED)
               && lock[sel_q] && req[sel_q]
               && (burst_cnt_q < CNT_W'(MAX_BURST));
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        dout_d  = '0;
        valid_d = 1'b0;
`ifdef ARB_LOCK_EN
        burst_cnt_d = burst_cnt_q;
`endif
        if (hold) begin
            state_d = LOCKED;
            gnt_d   = gnt_q;
            dout_d  = word[sel_q];
            valid_d = 1'b1;
`ifdef ARB_LOCK_EN
            burst_cnt_d = burst_cnt_q + 1'b1;
`endif
        end else if (pick_found) begin
            // ptr already points past any lock owner, so leaving LOCKED re-arbitrates here too.
            state_d = GRANT;
            gnt_d   = idx_to_onehot(pick_idx);
            sel_d   = pick_idx;
            ptr_d   = pick_idx + 1'b1;
            dout_d  = word[pick_idx];
            valid_d = 1'b1;
`ifdef ARB_LOCK_EN
            burst_cnt_d = CNT_W'(1);
`endif
        end else begin
            state_d = IDLE;
`ifdef ARB_LOCK_EN
            burst_cnt_d = '0;
`endif
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
`ifdef ARB_LOCK_EN
            burst_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
`ifdef ARB_LOCK_EN
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = (state_q != IDLE);

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_valid_match : assert property (@(posedge clk) disable iff (!rst_n) valid_q == (|gnt_q));

endmodule
